// File: rtl/assist_led_drv.sv
// -----------------------------------------------------------------------------
// assist_led_drv
//
// Purpose:
//   Drives the 3-segment assist-level LED bar on the handlebar from the 2-bit
//   assist setting supplied by the push-button interface. In steady state the
//   bar shows the setting at a PWM-controlled brightness. Whenever the setting
//   changes, a flash acknowledge (NUM_FLASH ON/OFF pairs, FLASH_HALF cycles per
//   phase, full brightness) is played so the rider sees the press was taken.
//
// Optional build macro:
//   LOWBAT_WARN_EN - adds the lowbat input. While lowbat is high in steady
//                    state the bar blinks, toggling every 4*FLASH_HALF cycles.
//                    Flash acknowledge is unaffected.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   setting  in   [1:0] current assist setting (0..3)
//   duty     in   [PWM_BITS-1:0] steady-state brightness duty
//   lowbat   in   low-battery warning level (LOWBAT_WARN_EN builds only)
//   led      out  [2:0] LED drive, bit0 = lowest bar segment
//   busy     out  high while the flash acknowledge runs
// -----------------------------------------------------------------------------
module assist_led_drv #(
  parameter int FLASH_HALF = 2500000,
  parameter int NUM_FLASH  = 3,
  parameter int PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          setting,
  input  logic [PWM_BITS-1:0] duty,
`ifdef LOWBAT_WARN_EN
  input  logic                lowbat,
`endif
  output logic [2:0]          led,
  output logic                busy
);

  localparam int HALF_W  = $clog2(FLASH_HALF);
  localparam int FLASH_W = $clog2(NUM_FLASH + 1);

  localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(FLASH_HALF - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(NUM_FLASH - 1);

  // Button interface comes out of reset at setting 2; matching it here keeps
  // reset release from looking like a button press.
  localparam logic [1:0] SETTING_RST = 2'b10;

  typedef enum logic [1:0] {
    STEADY,
    FLASH_ON,
    FLASH_OFF
  } state_t;

  function automatic logic [2:0] bar_of(input logic [1:0] s);
    logic [2:0] b;
    case (s)
      2'd0:    b = 3'b000;
      2'd1:    b = 3'b001;
      2'd2:    b = 3'b011;
      default: b = 3'b111;
    endcase
    return b;
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           prev_setting_q;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [HALF_W-1:0]    half_cnt_q, half_cnt_d;
  logic [FLASH_W-1:0]   flash_cnt_q, flash_cnt_d;
  logic [2:0]           led_q, led_d;
  logic                 busy_q, busy_d;

  logic                 change;
  logic                 pwm_on;
  logic                 half_done;
  logic [2:0]           steady_pat;

`ifdef LOWBAT_WARN_EN
  localparam int BLINK_W = $clog2(4 * FLASH_HALF);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(4 * FLASH_HALF - 1);

  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_q, blink_d;

  // Blink phase restarts from "off" every time lowbat is raised.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (lowbat) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end
`endif

  assign change    = (setting != prev_setting_q);
  // All-ones duty is forced fully on; plain compare would leave one dark slot.
  assign pwm_on    = (pwm_cnt_q < duty) || (&duty);
  assign half_done = (half_cnt_q == HALF_LAST);
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;

  always_comb begin
    steady_pat = bar_of(setting) & {3{pwm_on}};
`ifdef LOWBAT_WARN_EN
    if (lowbat) begin
      steady_pat = steady_pat & {3{blink_q}};
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    half_cnt_d  = half_cnt_q;
    flash_cnt_d = flash_cnt_q;
    led_d       = 3'b000;

    case (state_q)
      STEADY: begin
        led_d = steady_pat;
      end
      FLASH_ON: begin
        led_d = bar_of(setting);
        if (half_done) begin
          state_d    = FLASH_OFF;
          half_cnt_d = '0;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      FLASH_OFF: begin
        led_d = 3'b000;
        if (half_done) begin
          half_cnt_d  = '0;
          flash_cnt_d = flash_cnt_q + 1'b1;
          state_d     = (flash_cnt_q == FLASH_LAST) ? STEADY : FLASH_ON;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STEADY;
      end
    endcase

    // A new press always (re)starts the acknowledge, even on a terminal count.
    if (change) begin
      state_d     = FLASH_ON;
      half_cnt_d  = '0;
      flash_cnt_d = '0;
    end

    // busy mirrors the current state one cycle later, aligned with led.
    busy_d = (state_q != STEADY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= STEADY;
      prev_setting_q <= SETTING_RST;
      pwm_cnt_q      <= '0;
      half_cnt_q     <= '0;
      flash_cnt_q    <= '0;
      led_q          <= 3'b000;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_setting_q <= setting;
      pwm_cnt_q      <= pwm_cnt_d;
      half_cnt_q     <= half_cnt_d;
      flash_cnt_q    <= flash_cnt_d;
      led_q          <= led_d;
      busy_q         <= busy_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule
